// File: rtl/alu_op_issuer.sv
// Sequential initiator for a combinational ALU: takes tagged commands and returns tagged results.
// Optional feature: define ALU_ISSUER_ABS_EN to enable the two-pass ABS operation (opcode C).
module alu_op_issuer #(
  parameter int N    = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [N-1:0]    cmd_a,
  input  logic [N-1:0]    cmd_b,
  input  logic [TAGW-1:0] cmd_tag,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [4:0]      alu_fn,
  input  logic [N-1:0]    alu_r,
  input  logic            alu_z,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_r,
  output logic            rsp_z,
  output logic            rsp_err,
  output logic [TAGW-1:0] rsp_tag
);

  localparam logic [4:0] FN_ADD  = 5'b00001;
  localparam logic [4:0] FN_SUB  = 5'b10001;
  localparam logic [4:0] FN_AND  = 5'b00000;
  localparam logic [4:0] FN_OR   = 5'b00100;
  localparam logic [4:0] FN_XOR  = 5'b01000;
  localparam logic [4:0] FN_NOR  = 5'b01100;
  localparam logic [4:0] FN_SLL  = 5'b00010;
  localparam logic [4:0] FN_SRL  = 5'b01010;
  localparam logic [4:0] FN_SRA  = 5'b01110;
  localparam logic [4:0] FN_SLT  = 5'b10011;
  localparam logic [4:0] FN_SLTU = 5'b10111;

`ifdef ALU_ISSUER_ABS_EN
  typedef enum logic [1:0] {IDLE, EXEC, EXEC2, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

  state_t     state;
  logic [4:0] dec_fn;
  logic       dec_legal;
  logic       accept;
`ifdef ALU_ISSUER_ABS_EN
  logic       dec_abs;
  logic       is_abs;
`endif

  // A new command may enter while the previous response is being consumed.
  assign cmd_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    dec_fn    = FN_AND;
    dec_legal = 1'b1;
`ifdef ALU_ISSUER_ABS_EN
    dec_abs   = 1'b0;
`endif
    case (cmd_op)
      4'h0: dec_fn = FN_ADD;
      4'h1: dec_fn = FN_SUB;
      4'h2: dec_fn = FN_AND;
      4'h3: dec_fn = FN_OR;
      4'h4: dec_fn = FN_XOR;
      4'h5: dec_fn = FN_NOR;
      4'h6: dec_fn = FN_SLL;
      4'h7: dec_fn = FN_SRL;
      4'h8: dec_fn = FN_SRA;
      4'h9: dec_fn = FN_SLT;
      4'hA: dec_fn = FN_SLTU;
`ifdef ALU_ISSUER_ABS_EN
      4'hC: begin
        dec_fn  = FN_SLT;
        dec_abs = 1'b1;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fn    <= FN_AND;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_z     <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
`ifdef ALU_ISSUER_ABS_EN
      is_abs    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: ;
        EXEC: begin
`ifdef ALU_ISSUER_ABS_EN
          if (is_abs) begin
            // Pass 1 was "cmd_a < 0"; pass 2 negates or passes the operand through.
            if (alu_r[0]) begin
              alu_a  <= '0;
              alu_b  <= alu_a;
              alu_fn <= FN_SUB;
            end else begin
              alu_b  <= '0;
              alu_fn <= FN_ADD;
            end
            state <= EXEC2;
          end else begin
            rsp_r     <= alu_r;
            rsp_z     <= alu_z;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`else
          rsp_r     <= alu_r;
          rsp_z     <= alu_z;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
`endif
        end
`ifdef ALU_ISSUER_ABS_EN
        EXEC2: begin
          rsp_r     <= alu_r;
          rsp_z     <= alu_z;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Acceptance overrides the IDLE/RESP bookkeeping above.
      if (accept) begin
        rsp_tag <= cmd_tag;
        if (dec_legal) begin
          alu_fn <= dec_fn;
          alu_a  <= cmd_a;
`ifdef ALU_ISSUER_ABS_EN
          alu_b  <= dec_abs ? '0 : cmd_b;
          is_abs <= dec_abs;
`else
          alu_b  <= cmd_b;
`endif
          state  <= EXEC;
        end else begin
          rsp_r     <= '0;
          rsp_z     <= 1'b0;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
      end
    end
  end

endmodule
